// File: rtl/rv32i_inst_encoder_loader_pkg.sv
// rv32i_enc_pkg: symbolic op codes, RV32I major opcodes and funct fields for the instruction encoder.
package rv32i_enc_pkg;
    localparam logic [5:0] OP_ADD  = 6'd0,  OP_SUB  = 6'd1,  OP_SLL  = 6'd2,  OP_SLT   = 6'd3;
    localparam logic [5:0] OP_SLTU = 6'd4,  OP_XOR  = 6'd5,  OP_SRL  = 6'd6,  OP_SRA   = 6'd7;
    localparam logic [5:0] OP_OR   = 6'd8,  OP_AND  = 6'd9,  OP_ADDI = 6'd10, OP_SLTI  = 6'd11;
    localparam logic [5:0] OP_SLTIU = 6'd12, OP_XORI = 6'd13, OP_ORI = 6'd14, OP_ANDI  = 6'd15;
    localparam logic [5:0] OP_SLLI = 6'd16, OP_SRLI = 6'd17, OP_SRAI = 6'd18, OP_LB    = 6'd19;
    localparam logic [5:0] OP_LH   = 6'd20, OP_LW   = 6'd21, OP_LBU  = 6'd22, OP_LHU   = 6'd23;
    localparam logic [5:0] OP_SB   = 6'd24, OP_SH   = 6'd25, OP_SW   = 6'd26, OP_BEQ   = 6'd27;
    localparam logic [5:0] OP_BNE  = 6'd28, OP_BLT  = 6'd29, OP_BGE  = 6'd30, OP_BLTU  = 6'd31;
    localparam logic [5:0] OP_BGEU = 6'd32, OP_LAST = 6'd32;

    localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;

    localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
    localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_BU = 3'd4, F3_HU = 3'd5;
    localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;

    function automatic logic [2:0] funct3(input logic [5:0] op);
        case (op)
            OP_SLL, OP_SLLI:          return F3_SLL;
            OP_SLT, OP_SLTI:          return F3_SLT;
            OP_SLTU, OP_SLTIU:        return F3_SLTU;
            OP_XOR, OP_XORI:          return F3_XOR;
            OP_SRL, OP_SRA, OP_SRLI, OP_SRAI: return F3_SR;
            OP_OR, OP_ORI:            return F3_OR;
            OP_AND, OP_ANDI:          return F3_AND;
            OP_LH, OP_SH:             return F3_H;
            OP_LW, OP_SW:             return F3_W;
            OP_LBU:                   return F3_BU;
            OP_LHU:                   return F3_HU;
            OP_BNE:                   return F3_BNE;
            OP_BLT:                   return F3_BLT;
            OP_BGE:                   return F3_BGE;
            OP_BLTU:                  return F3_BLTU;
            OP_BGEU:                  return F3_BGEU;
            default:                  return F3_ADD;
        endcase
    endfunction
endpackage

// File: rtl/rv32i_inst_encoder_loader_if.sv
// rv32i_inst_encoder_loader_if: symbolic instruction request channel with valid/ready handshake.
interface rv32i_inst_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    modport master (output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, input in_ready);
    modport slave  (input in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, output in_ready);
endinterface

// File: rtl/rv32i_word_encoder.sv
// rv32i_word_encoder: combinational (op, rd, rs1, rs2, imm) -> RV32I word plus reject flag.
// ENCODER_RANGE_CHECK_EN rejects immediates that do not fit their field instead of truncating.
module rv32i_word_encoder
    import rv32i_enc_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        reject_o
);
    logic is_r, is_i, is_sh, is_ld, is_st, is_br;
    logic [2:0] f3;
    logic [6:0] f7;
    assign is_r  = op_i <= OP_AND;
    assign is_i  = op_i >= OP_ADDI && op_i <= OP_ANDI;
    assign is_sh = op_i >= OP_SLLI && op_i <= OP_SRAI;
    assign is_ld = op_i >= OP_LB && op_i <= OP_LHU;
    assign is_st = op_i >= OP_SB && op_i <= OP_SW;
    assign is_br = op_i >= OP_BEQ && op_i <= OP_BGEU;
    assign f3 = funct3(op_i);
    assign f7 = (op_i == OP_SUB || op_i == OP_SRA || op_i == OP_SRAI) ? F7_ALT : F7_BASE;
    always_comb begin
        word_o = is_r  ? {f7, rs2_i, rs1_i, f3, rd_i, OPC_R} :
                 is_sh ? {f7, imm_i[4:0], rs1_i, f3, rd_i, OPC_I} :
                 is_i  ? {imm_i[11:0], rs1_i, f3, rd_i, OPC_I} :
                 is_ld ? {imm_i[11:0], rs1_i, f3, rd_i, OPC_LOAD} :
                 is_st ? {imm_i[11:5], rs2_i, rs1_i, f3, imm_i[4:0], OPC_STORE} :
                 is_br ? {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3, imm_i[4:1], imm_i[11], OPC_BRANCH} :
                         32'd0;
    end
`ifdef ENCODER_RANGE_CHECK_EN
    logic i_ok, b_ok, s_ok;
    assign i_ok = &imm_i[31:11] || ~|imm_i[31:11];
    assign b_ok = (&imm_i[31:12] || ~|imm_i[31:12]) && !imm_i[0];
    assign s_ok = ~|imm_i[31:5];
    assign reject_o = op_i > OP_LAST || ((is_i || is_ld || is_st) && !i_ok) ||
                      (is_br && !b_ok) || (is_sh && !s_ok);
`else
    logic unused_imm;
    assign unused_imm = ^imm_i[31:13];
    assign reject_o = op_i > OP_LAST;
`endif
endmodule

// File: rtl/rv32i_inst_encoder_loader.sv
// rv32i_inst_encoder_loader: encodes symbolic requests and writes them to instruction memory from word 0.
// Optional ENCODER_RANGE_CHECK_EN turns out-of-range immediates into rejections.
module rv32i_inst_encoder_loader
    import rv32i_enc_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    rv32i_inst_encoder_loader_if.slave req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 full,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ADDR_W:0]      word_cnt
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);
    logic [31:0] word, wdata_q, wdata_d;
    logic rej, acc, we_q, we_d, err_q, err_d;
    logic [ADDR_W:0] ptr_q, ptr_d, cnt_q, cnt_d;
    logic [ERR_CNT_W-1:0] ecnt_q, ecnt_d;

    rv32i_word_encoder u_enc (
        .op_i(req.in_op), .rd_i(req.in_rd), .rs1_i(req.in_rs1), .rs2_i(req.in_rs2),
        .imm_i(req.in_imm), .word_o(word), .reject_o(rej)
    );

    assign full = cnt_q == DEPTH;
    assign req.in_ready = !full && !start;
    assign acc = req.in_valid && req.in_ready;

    // word_cnt counts accepted words including the one in flight; the pointer counts completed writes
    always_comb begin
        we_d    = acc && !rej;
        err_d   = acc && rej;
        wdata_d = acc ? word : wdata_q;
        ptr_d   = start ? '0 : ptr_q + (ADDR_W+1)'(we_q);
        cnt_d   = start ? '0 : cnt_q + (ADDR_W+1)'(we_d);
        ecnt_d  = start ? '0 : (err_d && !(&ecnt_q)) ? ecnt_q + ERR_CNT_W'(1) : ecnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ecnt_q  <= '0;
        end else begin
            we_q    <= we_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = ptr_q[ADDR_W-1:0];
    assign mem_wdata = wdata_q;
    assign err_pulse = err_q;
    assign err_cnt   = ecnt_q;
    assign word_cnt  = cnt_q;
endmodule

// File: tb/tb_rv32i_inst_encoder_loader.sv
// tb_rv32i_inst_encoder_loader: directed and random checks of the encoder/loader against an arithmetic RV32I model.
module tb_rv32i_inst_encoder_loader;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_s = 1'b0;
    always #5 clk = ~clk;
    int errors = 0, checks = 0;

    rv32i_inst_encoder_loader_if bi ();
    rv32i_inst_encoder_loader_if si ();

    logic d_we, d_full, d_err;
    logic [7:0] d_addr, d_ecnt;
    logic [31:0] d_wdata;
    logic [8:0] d_cnt;
    logic s_we, s_full, s_err;
    logic [1:0] s_addr, s_ecnt;
    logic [31:0] s_wdata;
    logic [2:0] s_cnt;

    rv32i_inst_encoder_loader #(.ADDR_W(8), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .req(bi), .mem_we(d_we), .mem_addr(d_addr),
        .mem_wdata(d_wdata), .full(d_full), .err_pulse(d_err), .err_cnt(d_ecnt), .word_cnt(d_cnt)
    );
    rv32i_inst_encoder_loader #(.ADDR_W(2), .ERR_CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .req(si), .mem_we(s_we), .mem_addr(s_addr),
        .mem_wdata(s_wdata), .full(s_full), .err_pulse(s_err), .err_cnt(s_ecnt), .word_cnt(s_cnt)
    );

    localparam int F3 [0:32] = '{0,0,1,2,3,4,5,5,6,7, 0,2,3,4,6,7, 1,5,5, 0,1,2,4,5, 0,1,2, 0,1,4,5,6,7};

    // Reference encoder: places each field by multiplying/dividing by powers of two
    function automatic void ref_enc(input int op, input logic [31:0] rd, rs1, rs2, imm,
                                    output logic [31:0] w, output bit rej);
        logic [31:0] f3, f7, opc;
`ifdef ENCODER_RANGE_CHECK_EN
        int s;
        s = $signed(imm);
`endif
        w = 0;
        rej = op > 32;
        if (rej) return;
        f3 = F3[op];
        if (op <= 9) begin
            f7 = (op == 1 || op == 7) ? 32 : 0;
            w = 32'h33 + rd * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576 + f7 * 33554432;
        end else if (op >= 16 && op <= 18) begin
            f7 = (op == 18) ? 32 : 0;
            w = 32'h13 + rd * 128 + f3 * 4096 + rs1 * 32768 + (imm % 32) * 1048576 + f7 * 33554432;
`ifdef ENCODER_RANGE_CHECK_EN
            rej = imm >= 32;
`endif
        end else if (op <= 23) begin
            opc = (op <= 15) ? 32'h13 : 32'h03;
            w = opc + rd * 128 + f3 * 4096 + rs1 * 32768 + (imm % 4096) * 1048576;
`ifdef ENCODER_RANGE_CHECK_EN
            rej = s < -2048 || s > 2047;
`endif
        end else if (op <= 26) begin
            w = 32'h23 + (imm % 32) * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576 +
                ((imm / 32) % 128) * 33554432;
`ifdef ENCODER_RANGE_CHECK_EN
            rej = s < -2048 || s > 2047;
`endif
        end else begin
            w = 32'h63 + ((imm / 2048) % 2) * 128 + ((imm / 2) % 16) * 256 + f3 * 4096 + rs1 * 32768 +
                rs2 * 1048576 + ((imm / 32) % 64) * 33554432 + ((imm / 4096) % 2) * 32'h80000000;
`ifdef ENCODER_RANGE_CHECK_EN
            rej = s < -4096 || s > 4095 || imm % 2 == 1;
`endif
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic [5:0] op, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm);
        bi.in_valid = v; bi.in_op = op; bi.in_rd = rd; bi.in_rs1 = rs1; bi.in_rs2 = rs2; bi.in_imm = imm;
    endtask

    task automatic set_s(input logic v, input logic [5:0] op, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm);
        si.in_valid = v; si.in_op = op; si.in_rd = rd; si.in_rs1 = rs1; si.in_rs2 = rs2; si.in_imm = imm;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_d(0, 0, 0, 0, 0, 0);
        set_s(0, 0, 0, 0, 0, 0);
        tick(); tick();
        checks++; if (d_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", d_we); end
        checks++; if (d_addr !== 8'd0) begin errors++; $display("FAIL reset_addr got %h want 0", d_addr); end
        checks++; if (d_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", d_wdata); end
        checks++; if ({d_full, d_err} !== 2'b00) begin errors++; $display("FAIL reset_full_err got %b want 00", {d_full, d_err}); end
        checks++; if (d_ecnt !== 8'd0) begin errors++; $display("FAIL reset_errcnt got %0d want 0", d_ecnt); end
        checks++; if (d_cnt !== 9'd0) begin errors++; $display("FAIL reset_wordcnt got %0d want 0", d_cnt); end
        checks++; if (bi.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bi.in_ready); end
        checks++; if ({s_we, s_full, s_err, s_cnt, s_ecnt} !== 8'd0) begin errors++; $display("FAIL reset_small got %b want 0", {s_we, s_full, s_err, s_cnt, s_ecnt}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        start = 1'b1;
        #1;
        checks++; if (bi.in_ready !== 1'b0) begin errors++; $display("FAIL start_ready got %b want 0", bi.in_ready); end
        tick();
        start = 1'b0;
        set_d(1, 6'd0, 5'd3, 5'd1, 5'd2, 0);
        tick();
        set_d(0, 0, 0, 0, 0, 0);
        checks++; if (d_we !== 1'b1) begin errors++; $display("FAIL add_we got %b want 1", d_we); end
        checks++; if (d_addr !== 8'd0) begin errors++; $display("FAIL add_addr got %h want 0", d_addr); end
        checks++; if (d_wdata !== 32'h002081B3) begin errors++; $display("FAIL add_word got %h want 002081B3", d_wdata); end
        checks++; if (d_cnt !== 9'd1) begin errors++; $display("FAIL add_cnt got %0d want 1", d_cnt); end
        tick();
        checks++; if (d_we !== 1'b0) begin errors++; $display("FAIL add_we_drop got %b want 0", d_we); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [5] = '{6'd1, 6'd10, 6'd18, 6'd26, 6'd27};
        logic [4:0] rds [5] = '{5'd5, 5'd1, 5'd4, 5'd0, 5'd0};
        logic [4:0] r1s [5] = '{5'd6, 5'd0, 5'd4, 5'd1, 5'd1};
        logic [4:0] r2s [5] = '{5'd7, 5'd0, 5'd0, 5'd2, 5'd2};
        logic [31:0] imms [5] = '{32'd0, 32'hFFFFFFFF, 32'd3, 32'd8, 32'hFFFFFFFC};
        logic [31:0] exps [5] = '{32'h407302B3, 32'hFFF00093, 32'h40325213, 32'h0020A423, 32'hFE208EE3};
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_d(1, ops[i], rds[i], r1s[i], r2s[i], imms[i]);
            #1;
            checks++; if (bi.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, bi.in_ready); end
            tick();
            checks++; if (d_we !== 1'b1 || d_addr !== 8'(i)) begin errors++; $display("FAIL b2b_we_addr[%0d] got %b/%0d want 1/%0d", i, d_we, d_addr, i); end
            checks++; if (d_wdata !== exps[i]) begin errors++; $display("FAIL b2b_word[%0d] got %h want %h", i, d_wdata, exps[i]); end
        end
        set_d(0, 0, 0, 0, 0, 0);
        checks++; if (d_cnt !== 9'd5) begin errors++; $display("FAIL b2b_cnt got %0d want 5", d_cnt); end
        tick();
    endtask

    task automatic test_invalid();
        set_d(1, 6'd40, 5'd1, 5'd1, 5'd1, 0);
        tick();
        set_d(0, 0, 0, 0, 0, 0);
        checks++; if (d_we !== 1'b0 || d_err !== 1'b1) begin errors++; $display("FAIL inv_we_err got %b%b want 01", d_we, d_err); end
        checks++; if (d_ecnt !== 8'd1 || d_cnt !== 9'd5) begin errors++; $display("FAIL inv_counts got %0d/%0d want 1/5", d_ecnt, d_cnt); end
        tick();
        checks++; if (d_err !== 1'b0 || d_ecnt !== 8'd1) begin errors++; $display("FAIL inv_pulse_end got %b/%0d want 0/1", d_err, d_ecnt); end
        set_d(1, 6'd10, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        set_d(0, 0, 0, 0, 0, 0);
        checks++; if (d_we !== 1'b1 || d_addr !== 8'd5 || d_wdata !== 32'h00500093) begin errors++; $display("FAIL inv_next got %b/%0d/%h want 1/5/00500093", d_we, d_addr, d_wdata); end
        tick();
    endtask

    task automatic test_range();
        set_d(1, 6'd10, 5'd1, 5'd0, 5'd0, 32'd2048);
        tick();
        set_d(0, 0, 0, 0, 0, 0);
`ifdef ENCODER_RANGE_CHECK_EN
        checks++; if (d_we !== 1'b0 || d_err !== 1'b1) begin errors++; $display("FAIL range_reject got %b%b want 01", d_we, d_err); end
        checks++; if (d_ecnt !== 8'd2 || d_cnt !== 9'd6) begin errors++; $display("FAIL range_counts got %0d/%0d want 2/6", d_ecnt, d_cnt); end
`else
        checks++; if (d_we !== 1'b1 || d_err !== 1'b0) begin errors++; $display("FAIL range_write got %b%b want 10", d_we, d_err); end
        checks++; if (d_wdata !== 32'h80000093 || d_addr !== 8'd6) begin errors++; $display("FAIL range_word got %h@%0d want 80000093@6", d_wdata, d_addr); end
`endif
        tick();
    endtask

    task automatic test_start_pending();
        logic [31:0] w;
        bit rej;
        start = 1'b1; tick(); start = 1'b0;
        set_d(1, 6'd9, 5'd1, 5'd2, 5'd3, 0);
        tick();
        set_d(1, 6'd5, 5'd9, 5'd8, 5'd7, 0);
        tick();
        start = 1'b1;
        set_d(1, 6'd8, 5'd10, 5'd11, 5'd12, 0);
        #1;
        ref_enc(5, 9, 8, 7, 0, w, rej);
        checks++; if (bi.in_ready !== 1'b0) begin errors++; $display("FAIL sp_ready got %b want 0", bi.in_ready); end
        checks++; if (d_we !== 1'b1 || d_addr !== 8'd1 || d_wdata !== w) begin errors++; $display("FAIL sp_pending got %b/%0d/%h want 1/1/%h", d_we, d_addr, d_wdata, w); end
        tick();
        start = 1'b0;
        checks++; if (d_we !== 1'b0 || d_cnt !== 9'd0) begin errors++; $display("FAIL sp_dropped got %b/%0d want 0/0", d_we, d_cnt); end
        tick();
        set_d(0, 0, 0, 0, 0, 0);
        ref_enc(8, 10, 11, 12, 0, w, rej);
        checks++; if (d_we !== 1'b1 || d_addr !== 8'd0 || d_wdata !== w) begin errors++; $display("FAIL sp_restart got %b/%0d/%h want 1/0/%h", d_we, d_addr, d_wdata, w); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_d(1, 6'd0, 5'd1, 5'd1, 5'd1, 0);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        checks++; if (d_we !== 1'b0 || d_cnt !== 9'd0) begin errors++; $display("FAIL rmid_state got %b/%0d want 0/0", d_we, d_cnt); end
        rst_n = 1'b1;
        set_d(0, 0, 0, 0, 0, 0);
        tick();
        checks++; if (bi.in_ready !== 1'b1 || d_we !== 1'b0 || d_cnt !== 9'd0) begin errors++; $display("FAIL rmid_after got %b/%b/%0d want 1/0/0", bi.in_ready, d_we, d_cnt); end
    endtask

    task automatic test_random();
        logic [31:0] w, imm;
        logic [5:0] op;
        logic [4:0] rd, rs1, rs2;
        bit rej, v, acc;
        int cnt = 0, ecnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            op = 6'($urandom_range(0, 40));
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            case ($urandom_range(0, 2))
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                default: imm = 32'($urandom_range(0, 40));
            endcase
            v = $urandom_range(0, 3) != 0;
            set_d(v, op, rd, rs1, rs2, imm);
            ref_enc(int'(op), rd, rs1, rs2, imm, w, rej);
            #1;
            checks++; if (bi.in_ready !== (cnt < 256)) begin errors++; $display("FAIL rnd_ready[%0d] got %b", i, bi.in_ready); end
            acc = v && cnt < 256;
            tick();
            checks++; if (d_we !== (acc && !rej) || d_err !== (acc && rej)) begin errors++; $display("FAIL rnd_we_err[%0d] op=%0d imm=%h got %b%b want %b%b", i, op, imm, d_we, d_err, acc && !rej, acc && rej); end
            if (acc && !rej) begin
                checks++; if (d_addr !== 8'(cnt) || d_wdata !== w) begin errors++; $display("FAIL rnd_word[%0d] op=%0d imm=%h got %h@%0d want %h@%0d", i, op, imm, d_wdata, d_addr, w, cnt); end
                cnt++;
            end
            if (acc && rej && ecnt < 255) ecnt++;
            checks++; if (d_cnt !== 9'(cnt) || d_ecnt !== 8'(ecnt)) begin errors++; $display("FAIL rnd_counts[%0d] got %0d/%0d want %0d/%0d", i, d_cnt, d_ecnt, cnt, ecnt); end
        end
        set_d(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_full();
        start_s = 1'b1; tick(); start_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_s(1, 6'd10, 5'(i + 1), 5'd0, 5'd0, 32'(i));
            #1;
            checks++; if (si.in_ready !== 1'b1) begin errors++; $display("FAIL full_ready[%0d] got %b want 1", i, si.in_ready); end
            tick();
            checks++; if (s_we !== 1'b1 || s_addr !== 2'(i) || s_full !== (i == 3)) begin errors++; $display("FAIL full_fill[%0d] got %b/%0d/%b", i, s_we, s_addr, s_full); end
        end
        set_s(1, 6'd10, 5'd9, 5'd0, 5'd0, 32'd9);
        #1;
        checks++; if (si.in_ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready got %b want 0", si.in_ready); end
        tick();
        checks++; if (s_we !== 1'b0 || s_cnt !== 3'd4 || s_full !== 1'b1) begin errors++; $display("FAIL full_held got %b/%0d/%b want 0/4/1", s_we, s_cnt, s_full); end
        tick();
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        checks++; if (s_we !== 1'b0 || s_cnt !== 3'd0 || s_full !== 1'b0) begin errors++; $display("FAIL full_start got %b/%0d/%b want 0/0/0", s_we, s_cnt, s_full); end
        tick();
        set_s(0, 0, 0, 0, 0, 0);
        checks++; if (s_we !== 1'b1 || s_addr !== 2'd0 || s_wdata !== 32'h00900493) begin errors++; $display("FAIL full_restart got %b/%0d/%h want 1/0/00900493", s_we, s_addr, s_wdata); end
        tick();
    endtask

    task automatic test_err_sat();
        start_s = 1'b1; tick(); start_s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_s(1, 6'd63, 5'd1, 5'd1, 5'd1, 0);
            tick();
            checks++; if (s_err !== 1'b1 || s_we !== 1'b0 || s_ecnt !== 2'((i < 3) ? i + 1 : 3)) begin errors++; $display("FAIL sat[%0d] got %b/%b/%0d want 1/0/%0d", i, s_err, s_we, s_ecnt, (i < 3) ? i + 1 : 3); end
        end
        set_s(0, 0, 0, 0, 0, 0);
        tick();
        checks++; if (s_err !== 1'b0 || s_ecnt !== 2'd3 || s_cnt !== 3'd0) begin errors++; $display("FAIL sat_hold got %b/%0d/%0d want 0/3/0", s_err, s_ecnt, s_cnt); end
        start_s = 1'b1; tick(); start_s = 1'b0;
        checks++; if (s_ecnt !== 2'd0) begin errors++; $display("FAIL sat_clear got %0d want 0", s_ecnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_invalid();
        test_range();
        test_start_pending();
        test_reset_mid();
        test_random();
        test_full();
        test_err_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv32i_inst_encoder_loader.md
Name: rv32i_inst_encoder_loader

Overview:
- Reverse direction of the RV32I instruction decoder: accepts symbolic instruction requests (op, rd, rs1, rs2, imm) over a valid/ready handshake.
- Encodes each request into a 32-bit RV32I word and writes it sequentially into instruction memory from address 0.
- Used for boot/self-test program loading, and by the bench to produce decoder stimulus.
- Reports rejected requests and the load fill level.

Parameters:
- ADDR_W, 8, instruction memory word-address width; capacity DEPTH = 2**ADDR_W words.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse: restart load at address 0, clear word_cnt and err_cnt.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_op  in  6  operation code (package list).
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed immediate, or shamt for shifts.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  encoded instruction.
- full  out  1  word_cnt == DEPTH.
- err_pulse  out  1  one cycle: previous accepted request rejected.
- err_cnt  out  ERR_CNT_W  saturating count of rejected requests.
- word_cnt  out  ADDR_W+1  number of words accepted for writing.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low (rst_n). All state updates on the rising edge of clk.
- Reset values: all outputs 0 except in_ready = 1. Reset mid-operation drops any pending write; the memory contents are not touched.
- Op codes:
  - 0–9: add sub sll slt sltu xor srl sra or and
  - 10–18: addi slti sltiu xori ori andi slli srli srai
  - 19–23: lb lh lw lbu lhu
  - 24–26: sb sh sw
  - 27–32: beq bne blt bge bltu bgeu
  - 33–63: invalid
- Formats and opcodes:
  - R-type, opcode 0110011: funct7 = 0100000 for sub/sra, else 0000000.
  - I-type ALU, opcode 0010011: imm[11:0].
  - Shifts (slli/srli/srai): upper field 0000000 (slli/srli) or 0100000 (srai); shamt = in_imm[4:0]; in_imm[31:5] ignored.
  - Loads, opcode 0000011: I-type.
  - Stores, opcode 0100011: imm[11:5] | rs2 | rs1 | f3 | imm[4:0].
  - Branches, opcode 1100011: imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11].
- Unused fields: forced to 0 (rs2 for I-type/loads, rd for stores/branches).
- Pipeline: one stage. A request accepted in cycle N gives mem_we = 1 in cycle N+1, with mem_addr = write pointer and mem_wdata = encoded word. The pointer increments after each write.
- Acceptance: in_ready = !full && !start.
  - start and in_valid in the same cycle: start wins, nothing accepted.
  - A write already pending from cycle N-1 still completes at the old pointer. The pointer then reloads to 0.
- Counting: word_cnt increments at acceptance of a valid request, so in-flight words count toward full. The last slot fills with full = 1 the following cycle.
- Rejection: an invalid op (or a failed range check) is accepted, produces no mem_we, and does not bump word_cnt. err_pulse = 1 in cycle N+1. err_cnt increments and saturates at all-ones.
- Back-to-back: one request per cycle sustained; there are no bubbles.
- When full: in_ready stays 0 until start or reset. The pointer does not wrap.

Optional Feature:
- Macro: ENCODER_RANGE_CHECK_EN.
- Defined:
  - I/S immediates must satisfy in_imm[31:11] all-equal.
  - Branch immediates must satisfy in_imm[31:12] all-equal and in_imm[0] = 0.
  - Shifts require in_imm[31:5] = 0.
  - A violation is a rejection.
- Undefined: immediates are silently truncated to their field; in_imm[0] of a branch is dropped.

Decomposition:
- Package rv32i_enc_pkg: op-code localparams 0–32, OP_LAST = 32, the 7-bit major opcodes, funct3 and funct7 constants.
- Sub-module rv32i_word_encoder: purely combinational, (op, rd, rs1, rs2, imm) -> (word, reject).
- Top level: handshake, write pointer, counters, error logic.

Test Plan:
- add rd=3 rs1=1 rs2=2 -> next cycle mem_we = 1, mem_addr = 0, mem_wdata = 0x002081B3.
- Back-to-back stream:
  - sub 5,6,7 -> 0x407302B3 @0
  - addi 1,0,-1 -> 0xFFF00093 @1
  - srai 4,4,3 -> 0x40325213 @2
  - sw rs2=2 rs1=1 imm=8 -> 0x0020A423 @3
  - beq 1,2,-4 -> 0xFE208EE3 @4
  - word_cnt = 5 at the end.
- in_op = 40 -> no mem_we, err_pulse = 1 for one cycle, err_cnt = 1, pointer unchanged. The next valid request is written at the same address.
- addi rd=1 rs1=0 imm=2048:
  - with ENCODER_RANGE_CHECK_EN: rejected, err_cnt increments.
  - without it: 0x80000093 written.
- ADDR_W = 2: after 4 accepted requests full = 1 and in_ready = 0. A 5th in_valid is held. start clears word_cnt and the next write goes to address 0.
- start asserted while a write is pending and in_valid = 1: the pending write completes and the new request is not accepted. rst_n low mid-stream: mem_we drops, word_cnt = 0, in_ready = 1 next cycle.
